// File: rtl/secded_pkg.sv
// Shared types for the SECDED (16,11) decode sequencer: FSM states, class flags, bit map.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package secded_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_LO,
      ST_RD_HI,
      ST_DECODE,
      ST_WR_LO,
      ST_WR_HI,
      ST_DONE
   } state_t;

   typedef logic [1:0] flag_t;

   localparam flag_t FLG_CLEAN  = 2'b00;
   localparam flag_t FLG_SINGLE = 2'b01;
   localparam flag_t FLG_DOUBLE = 2'b10;

   // Encoded word layout: parity bits sit at the power-of-two positions,
   // the overall parity at bit 0, data fills the remaining slots in order.
   localparam int P0_POS  = 0;
   localparam int P1_POS  = 1;
   localparam int P2_POS  = 2;
   localparam int P4_POS  = 4;
   localparam int P8_POS  = 8;
   localparam int D1_POS  = 3;
   localparam int D2_POS  = 5;
   localparam int D4_POS  = 7;
   localparam int D5_POS  = 9;
   localparam int D11_POS = 15;

   // Pull d11..d1 out of an encoded word, d11 in the MSB.
   function automatic logic [10:0] extract_data(input logic [15:0] w);
      return {w[D11_POS:D5_POS], w[D4_POS:D2_POS], w[D1_POS]};
   endfunction

endpackage

// File: rtl/secded_seq_if.sv
// Job control and data-memory port bundle between the sequencer and its host/memory.
// Latency: n/a (wires only).
// Backpressure: none; memory read data is combinational for mem_addr.
interface secded_seq_if #(
   parameter int AW = 8
);
   logic          start;
   logic          halt;
   logic          busy;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rdata;
   logic          mem_we;
   logic [7:0]    mem_wdata;
   logic [3:0]    single_cnt;
   logic [3:0]    double_cnt;

   modport master (
      input  start, mem_rdata,
      output halt, busy, mem_addr, mem_we, mem_wdata, single_cnt, double_cnt
   );

   modport slave (
      output start, mem_rdata,
      input  halt, busy, mem_addr, mem_we, mem_wdata, single_cnt, double_cnt
   );
endinterface

// File: rtl/secded_decode.sv
// Combinational SECDED (16,11) decoder: classify, correct single errors, emit flagged result.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module secded_decode
   import secded_pkg::*;
(
   input  logic [15:0] code_in,
   output logic [15:0] result,
   output flag_t       cls
);

   logic [3:0]  syn;
   logic        par;
   logic [15:0] fixed;

   // Syndrome/parity, then single-bit correction and result packing.
   always_comb begin
      syn = 4'd0;
      for (int i = 1; i < 16; i++) begin
         if (code_in[i]) syn = syn ^ 4'(i);
      end
      par   = ^code_in;
      fixed = code_in;
      cls   = FLG_CLEAN;
      if (par) begin
         // Odd overall parity: one flipped bit. s==0 means p0 itself flipped.
         cls = FLG_SINGLE;
         if (syn != 4'd0) fixed[syn] = ~fixed[syn];
      end else if (syn != 4'd0) begin
         // Even parity with a nonzero syndrome: two flips, not correctable.
         cls = FLG_DOUBLE;
      end
      result = {cls, 3'b000, extract_data(fixed)};
   end

endmodule

// File: rtl/secded_seq.sv
// Memory-walking SECDED decode job: read byte pairs, decode, write flagged results, halt.
// Latency: 5 cycles per word; halt one FSM step after the last high-byte write.
// Backpressure: none; relies on a combinational-read data memory with no wait states.
module secded_seq
   import secded_pkg::*;
#(
   parameter int NUM_WORDS = 15,
   parameter int SRC_BASE  = 30,
   parameter int DST_BASE  = 0,
   parameter int AW        = 8
) (
   input  logic            CLK,
   input  logic            Reset_n,
   secded_seq_if.master    bus
);

   localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [7:0]    lo_q, lo_d;
   logic [7:0]    hi_q, hi_d;
   logic [15:0]   res_q, res_d;
   logic [3:0]    scnt_q, scnt_d;
   logic [3:0]    dcnt_q, dcnt_d;

   logic [15:0]   dec_res;
   flag_t         dec_cls;
   logic [AW-1:0] idx_ext;
   logic [AW-1:0] word_off;
   logic [AW-1:0] src_lo;
   logic [AW-1:0] dst_lo;

   secded_decode u_dec (
      .code_in (({hi_q, lo_q})),
      .result  (dec_res),
      .cls     (dec_cls)
   );

   // Byte offset of the current word; address arithmetic wraps at AW bits.
   assign idx_ext  = AW'(idx_q);
   assign word_off = {idx_ext[AW-2:0], 1'b0};
   assign src_lo   = AW'(SRC_BASE) + word_off;
   assign dst_lo   = AW'(DST_BASE) + word_off;

   // Next-state logic: walk read/decode/write per word, accept start only when idle or done.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      res_d   = res_q;
      scnt_d  = scnt_q;
      dcnt_d  = dcnt_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_d = ST_RD_LO;
               idx_d   = '0;
               scnt_d  = 4'd0;
               dcnt_d  = 4'd0;
            end
         end
         ST_RD_LO: begin
            lo_d    = bus.mem_rdata;
            state_d = ST_RD_HI;
         end
         ST_RD_HI: begin
            hi_d    = bus.mem_rdata;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            res_d = dec_res;
            if (dec_cls == FLG_SINGLE && scnt_q != 4'hF) scnt_d = scnt_q + 4'd1;
            if (dec_cls == FLG_DOUBLE && dcnt_q != 4'hF) dcnt_d = dcnt_q + 4'd1;
            state_d = ST_WR_LO;
         end
         ST_WR_LO: begin
            state_d = ST_WR_HI;
         end
         ST_WR_HI: begin
            if (idx_q == IW'(NUM_WORDS - 1)) begin
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = ST_RD_LO;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts a job with no further writes.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         lo_q    <= 8'd0;
         hi_q    <= 8'd0;
         res_q   <= 16'd0;
         scnt_q  <= 4'd0;
         dcnt_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         res_q   <= res_d;
         scnt_q  <= scnt_d;
         dcnt_q  <= dcnt_d;
      end
   end

   // Memory port is a pure decode of the state so it drops to idle values with reset.
   always_comb begin
      bus.mem_addr  = '0;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = 8'd0;
      case (state_q)
         ST_RD_LO: bus.mem_addr = src_lo;
         ST_RD_HI: bus.mem_addr = src_lo + AW'(1);
         ST_WR_LO: begin
            bus.mem_addr  = dst_lo;
            bus.mem_we    = 1'b1;
            bus.mem_wdata = res_q[7:0];
         end
         ST_WR_HI: begin
            bus.mem_addr  = dst_lo + AW'(1);
            bus.mem_we    = 1'b1;
            bus.mem_wdata = res_q[15:8];
         end
         default: ;
      endcase
   end

   assign bus.halt       = (state_q == ST_DONE);
   assign bus.busy       = !(state_q == ST_IDLE || state_q == ST_DONE);
   assign bus.single_cnt = scnt_q;
   assign bus.double_cnt = dcnt_q;

endmodule

// File: tb/tb_secded_seq.sv
// Directed bench: single-word jobs, a full 15-word job, start pokes while busy, mid-job reset.
// Latency: checks start-to-halt of 5*N+1 cycles (start driven one cycle before it is sampled).
// Backpressure: memory model reads combinationally and writes on the rising edge.
module tb_secded_seq;
   import secded_pkg::*;

   logic CLK = 1'b0;
   logic Reset_n;
   always #5 CLK = ~CLK;

   secded_seq_if #(.AW(8)) if1 ();
   secded_seq_if #(.AW(8)) if15 ();

   secded_seq #(.NUM_WORDS(1)) dut1 (.CLK(CLK), .Reset_n(Reset_n), .bus(if1.master));
   secded_seq dut15 (.CLK(CLK), .Reset_n(Reset_n), .bus(if15.master));

   logic [15:0] ref_in;
   logic [15:0] ref_res;
   flag_t       ref_cls;
   secded_decode ref_dec (.code_in(ref_in), .result(ref_res), .cls(ref_cls));

   logic [7:0] mem1  [256];
   logic [7:0] mem15 [256];
   logic       ld_en, ld_sel, cnt_clr;
   logic [7:0] ld_addr, ld_data;
   int         wr_cnt;
   int         wr_hits [256];
   int         n_cmp, n_bad;

   assign if1.mem_rdata  = mem1[if1.mem_addr];
   assign if15.mem_rdata = mem15[if15.mem_addr];

   // Memories and write-strobe bookkeeping, owned by one process.
   always @(posedge CLK) begin
      if (cnt_clr) begin
         wr_cnt <= 0;
         for (int i = 0; i < 256; i++) wr_hits[i] <= 0;
      end else if (if15.mem_we) begin
         wr_cnt <= wr_cnt + 1;
         wr_hits[if15.mem_addr] <= wr_hits[if15.mem_addr] + 1;
      end
      if (ld_en && ld_sel) mem15[ld_addr] <= ld_data;
      else if (if15.mem_we) mem15[if15.mem_addr] <= if15.mem_wdata;
      if (ld_en && !ld_sel) mem1[ld_addr] <= ld_data;
      else if (if1.mem_we) mem1[if1.mem_addr] <= if1.mem_wdata;
   end

   // Single-word vectors and their hand-decoded results.
   logic [15:0] sw_code [4] = '{16'hFFFF, 16'h0020, 16'hFFFE, 16'h0006};
   logic [15:0] sw_exp  [4] = '{16'h07FF, 16'h4000, 16'h47FF, 16'h8000};
   int          sw_sng  [4] = '{0, 1, 1, 0};
   int          sw_dbl  [4] = '{0, 0, 0, 1};

   // Full-job mix: clean codewords, single flips (data and parity), double flips.
   logic [15:0] fj_code [15] = '{16'h0000, 16'hFFFF, 16'h000F, 16'h8117, 16'h0303,
                                16'h0020, 16'hFFFE, 16'h0006, 16'h0007, 16'h0117,
                                16'hFF7F, 16'h010B, 16'h3FFF, 16'h1001, 16'h0301};
   logic [15:0] fj_exp  [15] = '{16'h0000, 16'h07FF, 16'h0001, 16'h0400, 16'h0010,
                                16'h4000, 16'h47FF, 16'h8000, 16'h4001, 16'h4400,
                                16'h47FF, 16'h8001, 16'h81FF, 16'h8080, 16'h4010};

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic poke(input bit sel, input logic [7:0] a, input logic [7:0] d);
      ld_sel  = sel;
      ld_addr = a;
      ld_data = d;
      ld_en   = 1'b1;
      @(posedge CLK); #1;
      ld_en   = 1'b0;
   endtask

   task automatic clr_counts();
      cnt_clr = 1'b1;
      @(posedge CLK); #1;
      cnt_clr = 1'b0;
   endtask

   task automatic load_job();
      for (int i = 0; i < 15; i++) begin
         poke(1'b1, 8'(30 + 2 * i), fj_code[i][7:0]);
         poke(1'b1, 8'(31 + 2 * i), fj_code[i][15:8]);
      end
      for (int i = 0; i < 30; i++) poke(1'b1, 8'(i), 8'hEE);
      clr_counts();
   endtask

   // Pulse start, then count cycles until halt; optional start pokes while busy.
   task automatic run_job(input bit big, input bit pokes, output int lat);
      int n;
      logic h;
      @(posedge CLK); #1;
      if (big) if15.start = 1'b1; else if1.start = 1'b1;
      n   = 0;
      lat = -1;
      while (n < 200 && lat < 0) begin
         @(posedge CLK); #1;
         n++;
         if (big) if15.start = pokes && (n == 20 || n == 50);
         else     if1.start  = 1'b0;
         h = big ? if15.halt : if1.halt;
         if (n == 1) begin
            chk_eq("halt_low_after_start", 32'(h), 32'd0);
            chk_eq("busy_after_start", 32'(big ? if15.busy : if1.busy), 32'd1);
         end
         if (h) lat = n;
      end
      if15.start = 1'b0;
      if1.start  = 1'b0;
   endtask

   task automatic check_results(input string tag);
      int good;
      for (int i = 0; i < 15; i++) begin
         chk_eq($sformatf("%s_w%0d", tag, i), 32'({mem15[2 * i + 1], mem15[2 * i]}), 32'(fj_exp[i]));
      end
      good = 0;
      for (int a = 0; a < 30; a++) if (wr_hits[a] == 1) good++;
      chk_eq({tag, "_strobes"}, 32'(wr_cnt), 32'd30);
      chk_eq({tag, "_one_per_addr"}, 32'(good), 32'd30);
   endtask

   initial begin
      int lat;
      int kept;
      n_cmp = 0; n_bad = 0;
      ld_en = 1'b0; ld_sel = 1'b0; ld_addr = 8'd0; ld_data = 8'd0; cnt_clr = 1'b0;
      if1.start = 1'b0; if15.start = 1'b0; ref_in = 16'd0;
      Reset_n = 1'b0;
      repeat (3) @(posedge CLK); #1;

      chk_eq("rst_halt", 32'(if15.halt), 32'd0);
      chk_eq("rst_busy", 32'(if15.busy), 32'd0);
      chk_eq("rst_we", 32'(if15.mem_we), 32'd0);
      chk_eq("rst_addr", 32'(if15.mem_addr), 32'd0);
      chk_eq("rst_wdata", 32'(if15.mem_wdata), 32'd0);
      chk_eq("rst_scnt", 32'(if15.single_cnt), 32'd0);
      chk_eq("rst_dcnt", 32'(if15.double_cnt), 32'd0);
      Reset_n = 1'b1;

      // One-word jobs on the NUM_WORDS=1 instance.
      for (int t = 0; t < 4; t++) begin
         poke(1'b0, 8'd30, sw_code[t][7:0]);
         poke(1'b0, 8'd31, sw_code[t][15:8]);
         poke(1'b0, 8'd0, 8'hAA);
         poke(1'b0, 8'd1, 8'hAA);
         run_job(1'b0, 1'b0, lat);
         chk_eq($sformatf("w1_lat_%0d", t), 32'(lat), 32'd6);
         chk_eq($sformatf("w1_lo_%0d", t), 32'(mem1[0]), 32'(sw_exp[t][7:0]));
         chk_eq($sformatf("w1_hi_%0d", t), 32'(mem1[1]), 32'(sw_exp[t][15:8]));
         chk_eq($sformatf("w1_scnt_%0d", t), 32'(if1.single_cnt), 32'(sw_sng[t]));
         chk_eq($sformatf("w1_dcnt_%0d", t), 32'(if1.double_cnt), 32'(sw_dbl[t]));
      end

      // Reference decoder agrees with the hand-decoded table.
      for (int i = 0; i < 15; i++) begin
         ref_in = fj_code[i];
         #1;
         chk_eq($sformatf("ref_w%0d", i), 32'(ref_res), 32'(fj_exp[i]));
      end

      // Full job with start pokes while busy.
      load_job();
      run_job(1'b1, 1'b1, lat);
      chk_eq("full_lat", 32'(lat), 32'd76);
      chk_eq("full_scnt", 32'(if15.single_cnt), 32'd6);
      chk_eq("full_dcnt", 32'(if15.double_cnt), 32'd4);
      check_results("full");
      repeat (4) @(posedge CLK); #1;
      chk_eq("halt_held", 32'(if15.halt), 32'd1);

      // Reset during WR_LO of word 3.
      load_job();
      @(posedge CLK); #1;
      if15.start = 1'b1;
      @(posedge CLK); #1;
      if15.start = 1'b0;
      repeat (18) @(posedge CLK); #1;
      chk_eq("pre_rst_we", 32'(if15.mem_we), 32'd1);
      chk_eq("pre_rst_addr", 32'(if15.mem_addr), 32'd6);
      Reset_n = 1'b0;
      #1;
      chk_eq("mid_rst_we", 32'(if15.mem_we), 32'd0);
      chk_eq("mid_rst_addr", 32'(if15.mem_addr), 32'd0);
      chk_eq("mid_rst_wdata", 32'(if15.mem_wdata), 32'd0);
      chk_eq("mid_rst_busy", 32'(if15.busy), 32'd0);
      chk_eq("mid_rst_halt", 32'(if15.halt), 32'd0);
      repeat (2) @(posedge CLK); #1;
      Reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk_eq($sformatf("kept_w%0d", i), 32'({mem15[2 * i + 1], mem15[2 * i]}), 32'(fj_exp[i]));
      end
      kept = 0;
      for (int a = 6; a < 30; a++) if (mem15[a] == 8'hEE) kept++;
      chk_eq("untouched_after_rst", 32'(kept), 32'd24);
      chk_eq("strobes_before_rst", 32'(wr_cnt), 32'd6);

      // Fresh start reruns the whole job.
      for (int i = 0; i < 30; i++) poke(1'b1, 8'(i), 8'hEE);
      clr_counts();
      run_job(1'b1, 1'b0, lat);
      chk_eq("rerun_lat", 32'(lat), 32'd76);
      chk_eq("rerun_scnt", 32'(if15.single_cnt), 32'd6);
      chk_eq("rerun_dcnt", 32'(if15.double_cnt), 32'd4);
      check_results("rerun");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
